// File: rtl/alu_share_arbiter_if.sv
// Request/response/ALU bundle shared between alu_share_arbiter and its environment.
// slave = arbiter side, master = requesters + response consumer + shared ALU.
interface alu_share_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
);
  logic              req0_valid_i, req0_ready_o;
  logic [DATA_W-1:0] req0_src1_i, req0_src2_i;
  logic [CTRL_W-1:0] req0_ctrl_i;
  logic              req1_valid_i, req1_ready_o;
  logic [DATA_W-1:0] req1_src1_i, req1_src2_i;
  logic [CTRL_W-1:0] req1_ctrl_i;
  logic              rsp_valid_o, rsp_ready_i, rsp_id_o, rsp_zero_o, rsp_err_o;
  logic [DATA_W-1:0] rsp_result_o;
  logic [DATA_W-1:0] alu_src1_o, alu_src2_o, alu_result_i;
  logic [CTRL_W-1:0] alu_ctrl_o;

  modport slave (
    input  req0_valid_i, req0_src1_i, req0_src2_i, req0_ctrl_i,
    input  req1_valid_i, req1_src1_i, req1_src2_i, req1_ctrl_i,
    input  rsp_ready_i, alu_result_i,
    output req0_ready_o, req1_ready_o,
    output rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o, rsp_err_o,
    output alu_src1_o, alu_src2_o, alu_ctrl_o
  );

  modport master (
    output req0_valid_i, req0_src1_i, req0_src2_i, req0_ctrl_i,
    output req1_valid_i, req1_src1_i, req1_src2_i, req1_ctrl_i,
    output rsp_ready_i, alu_result_i,
    input  req0_ready_o, req1_ready_o,
    input  rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o, rsp_err_o,
    input  alu_src1_o, alu_src2_o, alu_ctrl_o
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters (IDLE->EXEC->RESP).
// Optional grant counters are built only when ALU_ARB_STATS_EN is defined.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  alu_share_arbiter_if.slave bus,
  output logic             busy_o,
  output logic [CNT_W-1:0] grant_cnt0_o,
  output logic [CNT_W-1:0] grant_cnt1_o
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            r_state, w_nstate;
  logic              r_last_grant, r_id, r_illegal;
  logic [DATA_W-1:0] r_src1, r_src2;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_rsp_id, r_rsp_zero, r_rsp_err;
  logic [DATA_W-1:0] r_rsp_result;

  logic              w_gnt_id, w_ready0, w_ready1, w_hs, w_legal;
  logic [DATA_W-1:0] w_src1, w_src2;
  logic [CTRL_W-1:0] w_ctrl;

  function automatic logic is_legal(input logic [CTRL_W-1:0] c);
    return (c == CTRL_W'(0)) || (c == CTRL_W'(1)) || (c == CTRL_W'(2)) ||
           (c == CTRL_W'(6)) || (c == CTRL_W'(7));
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    w_gnt_id = 1'b0;
    w_ready0 = 1'b0;
    w_ready1 = 1'b0;
    case (r_state)
      IDLE: begin
        // On a tie the requester that did not win last time gets the grant.
        if (bus.req0_valid_i && bus.req1_valid_i) w_gnt_id = ~r_last_grant;
        else                                      w_gnt_id = bus.req1_valid_i;
        w_ready0 = bus.req0_valid_i && !w_gnt_id;
        w_ready1 = bus.req1_valid_i &&  w_gnt_id;
        if (w_ready0 || w_ready1) w_nstate = EXEC;
      end
      EXEC:    w_nstate = RESP;
      RESP:    if (bus.rsp_ready_i) w_nstate = IDLE;
      default: w_nstate = IDLE;
    endcase
  end

  assign w_hs    = w_ready0 || w_ready1;
  assign w_src1  = w_gnt_id ? bus.req1_src1_i : bus.req0_src1_i;
  assign w_src2  = w_gnt_id ? bus.req1_src2_i : bus.req0_src2_i;
  assign w_ctrl  = w_gnt_id ? bus.req1_ctrl_i : bus.req0_ctrl_i;
  assign w_legal = is_legal(w_ctrl);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_illegal    <= 1'b0;
      r_src1       <= '0;
      r_src2       <= '0;
      r_ctrl       <= '0;
      r_rsp_id     <= 1'b0;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_result <= '0;
    end else begin
      if (w_hs) begin
        r_src1       <= w_src1;
        r_src2       <= w_src2;
        // Illegal codes still run through the ALU, but as a harmless AND.
        r_ctrl       <= w_legal ? w_ctrl : '0;
        r_illegal    <= !w_legal;
        r_id         <= w_gnt_id;
        r_last_grant <= w_gnt_id;
      end
      if (r_state == EXEC) begin
        r_rsp_id     <= r_id;
        r_rsp_result <= r_illegal ? '0 : bus.alu_result_i;
        r_rsp_zero   <= r_illegal || (bus.alu_result_i == '0);
        r_rsp_err    <= r_illegal;
      end
    end
  end

  assign bus.req0_ready_o = w_ready0;
  assign bus.req1_ready_o = w_ready1;
  assign bus.rsp_valid_o  = (r_state == RESP);
  assign bus.rsp_id_o     = r_rsp_id;
  assign bus.rsp_result_o = r_rsp_result;
  assign bus.rsp_zero_o   = r_rsp_zero;
  assign bus.rsp_err_o    = r_rsp_err;
  assign bus.alu_src1_o   = (r_state != IDLE) ? r_src1 : '0;
  assign bus.alu_src2_o   = (r_state != IDLE) ? r_src2 : '0;
  assign bus.alu_ctrl_o   = (r_state != IDLE) ? r_ctrl : '0;
  assign busy_o           = (r_state != IDLE);

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] r_cnt0, r_cnt1;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_ready0) r_cnt0 <= r_cnt0 + 1'b1;
      if (w_ready1) r_cnt1 <= r_cnt1 + 1'b1;
    end
  end
  assign grant_cnt0_o = r_cnt0;
  assign grant_cnt1_o = r_cnt1;
`else
  assign grant_cnt0_o = '0;
  assign grant_cnt1_o = '0;
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed steps then random traffic, scored against a
// transaction-level model (grant choice, fixed 2-cycle response delay, ALU semantics).
module tb_alu_share_arbiter;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int NW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          busy_o;
  logic [NW-1:0] grant_cnt0_o, grant_cnt1_o;

  alu_share_arbiter_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();

  alu_share_arbiter #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus.slave),
    .busy_o(busy_o), .grant_cnt0_o(grant_cnt0_o), .grant_cnt1_o(grant_cnt1_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [DW-1:0] alu_fn(input logic [CW-1:0] c, input logic [DW-1:0] a, b);
    case (c)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // The shared ALU itself lives in the environment.
  always_comb bus.alu_result_i = alu_fn(bus.alu_ctrl_o, bus.alu_src1_o, bus.alu_src2_o);

  int total = 0;
  int bad   = 0;
  int cnum  = 0;

  // Transaction-level model state
  bit          m_pend = 0;
  int          m_tacc = 0;
  int          m_last = 1;
  int          m_cnt0 = 0, m_cnt1 = 0;
  logic        m_id, m_zero, m_err;
  logic [DW-1:0] m_s1, m_s2, m_res;
  logic [CW-1:0] m_actrl;
  int          gq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cnum);
    end
  endtask

  task automatic set_req(input int n, input bit v, input logic [DW-1:0] a, b, input logic [CW-1:0] c);
    if (n == 0) begin
      bus.req0_valid_i = v; bus.req0_src1_i = a; bus.req0_src2_i = b; bus.req0_ctrl_i = c;
    end else begin
      bus.req1_valid_i = v; bus.req1_src1_i = a; bus.req1_src2_i = b; bus.req1_ctrl_i = c;
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
  endtask

  // One clock cycle: inputs already driven at posedge+1; sample at posedge+2.
  task automatic cyc();
    int g;
    logic e_rv;
    logic [CW-1:0] c;
    #1;
    g = -1;
    if (!m_pend) begin
      if (bus.req0_valid_i && bus.req1_valid_i) g = (m_last == 1) ? 0 : 1;
      else if (bus.req0_valid_i) g = 0;
      else if (bus.req1_valid_i) g = 1;
    end
    e_rv = m_pend && (cnum >= m_tacc + 2);
    chk("req0_ready", 64'(bus.req0_ready_o), 64'(g == 0));
    chk("req1_ready", 64'(bus.req1_ready_o), 64'(g == 1));
    chk("busy", 64'(busy_o), 64'(m_pend));
    chk("rsp_valid", 64'(bus.rsp_valid_o), 64'(e_rv));
    chk("alu_src1", 64'(bus.alu_src1_o), m_pend ? 64'(m_s1) : 64'd0);
    chk("alu_src2", 64'(bus.alu_src2_o), m_pend ? 64'(m_s2) : 64'd0);
    chk("alu_ctrl", 64'(bus.alu_ctrl_o), m_pend ? 64'(m_actrl) : 64'd0);
    if (e_rv) begin
      chk("rsp_id", 64'(bus.rsp_id_o), 64'(m_id));
      chk("rsp_result", 64'(bus.rsp_result_o), 64'(m_res));
      chk("rsp_zero", 64'(bus.rsp_zero_o), 64'(m_zero));
      chk("rsp_err", 64'(bus.rsp_err_o), 64'(m_err));
    end
`ifdef ALU_ARB_STATS_EN
    chk("grant_cnt0", 64'(grant_cnt0_o), 64'(m_cnt0 % 65536));
    chk("grant_cnt1", 64'(grant_cnt1_o), 64'(m_cnt1 % 65536));
`else
    chk("grant_cnt0", 64'(grant_cnt0_o), 64'd0);
    chk("grant_cnt1", 64'(grant_cnt1_o), 64'd0);
`endif
    if (e_rv && bus.rsp_ready_i) m_pend = 0;
    if (g >= 0) begin
      m_s1 = (g == 0) ? bus.req0_src1_i : bus.req1_src1_i;
      m_s2 = (g == 0) ? bus.req0_src2_i : bus.req1_src2_i;
      c    = (g == 0) ? bus.req0_ctrl_i : bus.req1_ctrl_i;
      m_err   = !(c inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7});
      m_actrl = m_err ? 4'd0 : c;
      m_res   = m_err ? '0 : alu_fn(c, m_s1, m_s2);
      m_zero  = (m_res == 0);
      m_id    = (g == 1);
      m_pend  = 1; m_tacc = cnum; m_last = g;
      gq.push_back(g);
      if (g == 0) m_cnt0++; else m_cnt1++;
    end
    @(posedge clk_i); #1;
    cnum++;
  endtask

  initial begin
    logic [CW-1:0] legal [5];
    legal = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7};
    set_req(0, 0, '0, '0, '0);
    set_req(1, 0, '0, '0, '0);
    bus.rsp_ready_i = 1'b1;

    // Reset values
    #1;
    chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("rst_rsp_result", 64'(bus.rsp_result_o), 64'd0);
    chk("rst_rsp_zero", 64'(bus.rsp_zero_o), 64'd0);
    chk("rst_rsp_err", 64'(bus.rsp_err_o), 64'd0);
    chk("rst_rsp_id", 64'(bus.rsp_id_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_alu_src1", 64'(bus.alu_src1_o), 64'd0);
    chk("rst_cnt0", 64'(grant_cnt0_o), 64'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // ADD 5+3 from requester 0
    set_req(0, 1, 32'd5, 32'd3, 4'b0010);
    cyc();
    set_req(0, 0, '0, '0, '0);
    cyc();
    chk("add_ctrl_T1", 64'(bus.alu_ctrl_o), 64'h2);
    cyc();

    // SLT 2<9 from requester 1 with a stalled consumer; requester 0 knocks meanwhile
    set_req(1, 1, 32'd2, 32'd9, 4'b0111);
    cyc();
    set_req(1, 0, '0, '0, '0);
    set_req(0, 1, 32'h1, 32'h1, 4'b0010);
    bus.rsp_ready_i = 1'b0;
    cyc();
    repeat (4) cyc();
    chk("slt_result", 64'(bus.rsp_result_o), 64'd1);
    set_req(0, 0, '0, '0, '0);
    bus.rsp_ready_i = 1'b1;
    cyc();

    // Both valid continuously: strict alternation starting with requester 0
    gq.delete();
    set_req(0, 1, 32'd7, 32'd7, 4'b0110);
    set_req(1, 1, 32'hF0, 32'h0F, 4'b0001);
    repeat (12) cyc();
    set_req(0, 0, '0, '0, '0);
    set_req(1, 0, '0, '0, '0);
    chk("rr_count", 64'(gq.size()), 64'd4);
    foreach (gq[i]) chk("rr_order", 64'(gq[i]), 64'(i % 2));

    // Illegal ctrl code
    set_req(0, 1, 32'hFFFF_0000, 32'h0F0F_FFFF, 4'b1111);
    cyc();
    set_req(0, 0, '0, '0, '0);
    cyc();
    cyc();

    // Reset while a response is pending
    set_req(1, 1, 32'd10, 32'd4, 4'b0110);
    bus.rsp_ready_i = 1'b0;
    cyc();
    set_req(1, 0, '0, '0, '0);
    cyc();
    #1;
    chk("pre_rst_valid", 64'(bus.rsp_valid_o), 64'd1);
    rst_i = 1'b1;
    #1;
    chk("async_rst_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("async_rst_busy", 64'(busy_o), 64'd0);
    chk("async_rst_cnt1", 64'(grant_cnt1_o), 64'd0);
    model_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    bus.rsp_ready_i = 1'b1;
    gq.delete();
    set_req(0, 1, 32'd1, 32'd2, 4'b0010);
    set_req(1, 1, 32'd3, 32'd4, 4'b0010);
    cyc();
    chk("post_rst_first", 64'(gq[0]), 64'd0);
    set_req(0, 0, '0, '0, '0);
    set_req(1, 0, '0, '0, '0);
    repeat (2) cyc();

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      for (int n = 0; n < 2; n++) begin
        logic [DW-1:0] a, b;
        logic [CW-1:0] c;
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : DW'($urandom);
        if ($urandom_range(0, 3) == 0) begin a = a & 32'hF; b = b & 32'hF; end
        c = ($urandom_range(0, 7) == 0) ? CW'($urandom) : legal[$urandom_range(0, 4)];
        set_req(n, bit'($urandom_range(0, 1)), a, b, c);
      end
      bus.rsp_ready_i = ($urandom_range(0, 9) < 7);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
